clock: RTL and testbench
========================

Name: clock

Overview:
Timebase and sampling block for a single clock domain. It registers a 3-bit data bus on every rising clock edge. It also generates a programmable tick enable, a divided clock-phase signal and a free-running cycle counter. Downstream logic uses it as a common time reference and data sampler.

Parameters:
DATA_W, 3, width of sampled data bus d/q
DIV_W, 8, width of divider ratio input div
CNT_W, 16, width of free-running cycle counter

Ports:
clk  input  1  system clock; all state updates on rising edge
rst  input  1  asynchronous, active-high reset
en  input  1  timebase enable; gates divider and cycle counter only
d  input  DATA_W  data to sample
div  input  DIV_W  divider ratio; tick period is div+1 cycles
q  output  DATA_W  registered copy of d
tick  output  1  one-cycle pulse every div+1 enabled cycles
clk_div  output  1  divided phase; toggles on every tick
cycle_count  output  CNT_W  count of enabled cycles since reset
wrap  output  1  one-cycle pulse when cycle_count wraps to 0

Behaviour:
- Single clock clk. Reset rst is asynchronous and active-high. While rst=1: q=0, tick=0, clk_div=0, cycle_count=0, wrap=0, divider counter=0.
- Reset release is taken on the next rising clk edge. The first edge with rst=0 behaves as a normal cycle.
- Reset asserted mid-operation clears all state immediately, independent of clk.
- q: q <= d on every rising edge, independent of en. Latency is 1 cycle. d changing between edges has no effect until the next edge.
- Divider: internal counter dcnt (DIV_W bits). When en=1:
  - if dcnt >= div: dcnt <= 0, tick <= 1, clk_div <= ~clk_div
  - else: dcnt <= dcnt+1, tick <= 0
- div=0 gives tick=1 on every enabled cycle, and clk_div toggles every cycle (clk/2).
- div may change at any time and is compared live. If dcnt already exceeds the new div, the block ticks and wraps on the next enabled edge; no lockup is possible.
- en=0: dcnt, clk_div and cycle_count hold their values, and tick=0 and wrap=0 on that edge.
- cycle_count: increments by 1 per enabled edge and wraps from all-ones to 0. On that edge wrap <= 1; otherwise wrap <= 0.
- All outputs are registered. There are no combinational paths from inputs to outputs.
- Arithmetic is unsigned, modulo 2^width. No saturation.

Decomposition:
- Shared package clock_pkg holds DATA_W, DIV_W and CNT_W defaults, plus localparam CNT_MAX = all-ones.
- One sub-module, clock_divider, contains dcnt, tick and clk_div, with ports clk, rst, en, div, tick, clk_div.
- The top-level clock holds the q register, cycle_count and wrap, and instantiates clock_divider.

Test Plan:
1. Data sampling: rst pulse, then d=0,1,2,...,7, changing every half clock period (clk period 4, first rising edge at t=4). q must show only the d value present at each rising edge, one cycle late (1, 3, 5, 7 at successive edges). q never changes between edges.
2. Reset: assert rst asynchronously mid-cycle with q=5, cycle_count=37 and clk_div=1. All outputs go to 0 without a clock edge. After release, cycle_count=1 at the first edge.
3. Divider: en=1, div=3. tick pulses on every 4th edge (cycles 4, 8, 12 after reset). clk_div toggles each tick. Then div=0: tick is high every cycle and clk_div toggles every cycle.
4. Live div change: div=10, wait until dcnt=7, set div=2. tick is asserted on the next edge and dcnt returns to 0. The following tick period is 3 cycles.
5. Enable gating: en=0 for 5 cycles mid-period. cycle_count, dcnt and clk_div are frozen, and tick=0 and wrap=0. q still tracks d. With en=1 the counters resume from their held values.
6. Counter wrap: run 65535 enabled cycles (or force the count near max in simulation). cycle_count goes 0xFFFF -> 0x0000, with wrap=1 for exactly that one cycle.

Source files
------------

// File: rtl/clock_pkg.sv
// Shared widths, types and constants for the clock timebase block.
package clock_pkg;

  localparam int unsigned DATA_W = 3;
  localparam int unsigned DIV_W  = 8;
  localparam int unsigned CNT_W  = 16;

  typedef logic [DATA_W-1:0] data_t;
  typedef logic [DIV_W-1:0]  div_t;
  typedef logic [CNT_W-1:0]  cnt_t;

  localparam cnt_t CNT_MAX = '1;

  // Greater-or-equal rather than equality, so a ratio lowered below the
  // running count still produces a tick instead of locking up.
  function automatic logic tick_due(input div_t dcnt, input div_t div);
    return dcnt >= div;
  endfunction

endpackage

// File: rtl/clock_if.sv
// Data, divider control and timebase outputs of the clock block.
interface clock_if;
  import clock_pkg::*;

  logic  en;
  data_t d;
  div_t  div;
  data_t q;
  logic  tick;
  logic  clk_div;
  cnt_t  cycle_count;
  logic  wrap;

  modport master (
    output en, d, div,
    input  q, tick, clk_div, cycle_count, wrap
  );

  modport slave (
    input  en, d, div,
    output q, tick, clk_div, cycle_count, wrap
  );

endinterface

// File: rtl/clock_divider.sv
// Programmable tick generator: pulses every div+1 enabled cycles, toggles clk_div per tick.
module clock_divider
  import clock_pkg::*;
(
  input  logic clk,
  input  logic rst,
  input  logic en,
  input  div_t div,
  output logic tick,
  output logic clk_div
);

  div_t dcnt_q, dcnt_d;
  logic tick_q, tick_d;
  logic clk_div_q, clk_div_d;

  always_comb begin
    dcnt_d    = dcnt_q;
    tick_d    = 1'b0;
    clk_div_d = clk_div_q;
    if (en) begin
      if (tick_due(dcnt_q, div)) begin
        dcnt_d    = '0;
        tick_d    = 1'b1;
        clk_div_d = ~clk_div_q;
      end else begin
        dcnt_d = dcnt_q + DIV_W'(1);
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      dcnt_q    <= '0;
      tick_q    <= 1'b0;
      clk_div_q <= 1'b0;
    end else begin
      dcnt_q    <= dcnt_d;
      tick_q    <= tick_d;
      clk_div_q <= clk_div_d;
    end
  end

  assign tick    = tick_q;
  assign clk_div = clk_div_q;

endmodule

// File: rtl/clock.sv
// Timebase and sampler: registers d, counts enabled cycles, flags counter wrap.
module clock
  import clock_pkg::*;
(
  input logic     clk,
  input logic     rst,
  clock_if.slave  bus
);

  data_t q_q;
  cnt_t  cnt_q, cnt_d;
  logic  wrap_q, wrap_d;

  always_comb begin
    cnt_d  = cnt_q;
    wrap_d = 1'b0;
    if (bus.en) begin
      cnt_d  = cnt_q + CNT_W'(1);
      wrap_d = (cnt_q == CNT_MAX);
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      q_q    <= '0;
      cnt_q  <= '0;
      wrap_q <= 1'b0;
    end else begin
      q_q    <= bus.d;
      cnt_q  <= cnt_d;
      wrap_q <= wrap_d;
    end
  end

  clock_divider u_div (
    .clk     (clk),
    .rst     (rst),
    .en      (bus.en),
    .div     (bus.div),
    .tick    (bus.tick),
    .clk_div (bus.clk_div)
  );

  assign bus.q           = q_q;
  assign bus.cycle_count = cnt_q;
  assign bus.wrap        = wrap_q;

endmodule

// File: tb/tb_clock.sv
// Directed scoreboard bench for the clock timebase block.
module tb_clock;
  import clock_pkg::*;

  typedef struct {
    logic [2:0]  q;
    logic        tick;
    logic        clk_div;
    logic [15:0] cnt;
    logic        wrap;
    logic [7:0]  dcnt;
  } exp_t;

  logic clk;
  logic rst;
  clock_if bus ();

  clock dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  initial begin
    clk = 1'b0;
    #4 clk = 1'b1;
    forever #2 clk = ~clk;
  end

  int   tests = 0;
  int   fails = 0;
  exp_t sb[$];

  logic [2:0]  m_q;
  logic        m_tick, m_clkdiv, m_wrap;
  logic [15:0] m_cnt;
  logic [7:0]  m_dcnt;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    m_q = '0; m_tick = 1'b0; m_clkdiv = 1'b0; m_wrap = 1'b0; m_cnt = '0; m_dcnt = '0;
    sb.delete();
  endtask

  // Drive inputs one time unit after an edge, predict the next edge, check after it.
  task automatic step(input logic e, input logic [2:0] dv, input logic [7:0] dd, input bit do_chk);
    exp_t x;
    bus.en = e; bus.d = dv; bus.div = dd;
    m_q = dv;
    if (e) begin
      if (m_dcnt >= dd) begin
        m_dcnt = 8'd0; m_tick = 1'b1; m_clkdiv = ~m_clkdiv;
      end else begin
        m_dcnt = m_dcnt + 8'd1; m_tick = 1'b0;
      end
      m_wrap = (m_cnt == 16'hFFFF);
      m_cnt  = m_cnt + 16'd1;
    end else begin
      m_tick = 1'b0; m_wrap = 1'b0;
    end
    x.q = m_q; x.tick = m_tick; x.clk_div = m_clkdiv;
    x.cnt = m_cnt; x.wrap = m_wrap; x.dcnt = m_dcnt;
    sb.push_back(x);
    @(posedge clk);
    #1;
    if (sb.size() == 0) begin
      chk("sb_empty", 32'd1, 32'd0);
    end else begin
      x = sb.pop_front();
      if (do_chk) begin
        chk("q",       32'(bus.q),               32'(x.q));
        chk("tick",    32'(bus.tick),            32'(x.tick));
        chk("clk_div", 32'(bus.clk_div),         32'(x.clk_div));
        chk("count",   32'(bus.cycle_count),     32'(x.cnt));
        chk("wrap",    32'(bus.wrap),            32'(x.wrap));
        chk("dcnt",    32'(dut.u_div.dcnt_q),    32'(x.dcnt));
      end
    end
  endtask

  task automatic chk_all_zero(input string tag);
    chk({tag, "_q"},       32'(bus.q),           32'd0);
    chk({tag, "_tick"},    32'(bus.tick),        32'd0);
    chk({tag, "_clk_div"}, 32'(bus.clk_div),     32'd0);
    chk({tag, "_count"},   32'(bus.cycle_count), 32'd0);
    chk({tag, "_wrap"},    32'(bus.wrap),        32'd0);
  endtask

  initial begin
    logic [2:0] qexp;
    logic [2:0] qpipe[$];
    int         guard;

    rst = 1'b0; bus.en = 1'b0; bus.d = '0; bus.div = '0;
    model_reset();

    // Reset state
    #1 rst = 1'b1;
    #1 chk_all_zero("rst0");
    rst = 1'b0;

    // Data sampling: d steps every half period, odd values land on rising edges
    #1 bus.d = 3'd1;
    qpipe.push_back(3'd1);
    qexp = '0;
    for (int k = 2; k < 8; k++) begin
      #2;
      if ((k % 2) == 0) qexp = qpipe.pop_front();
      chk("samp_q", 32'(bus.q), 32'(qexp));
      bus.d = 3'(k);
      if ((k % 2) == 1) qpipe.push_back(3'(k));
    end
    #2;
    qexp = qpipe.pop_front();
    chk("samp_q_last", 32'(bus.q), 32'(qexp));
    chk("samp_count_idle", 32'(bus.cycle_count), 32'd0);
    m_q = 3'd7;

    // Divider div=3 for 37 enabled cycles, last d=5
    for (int i = 0; i < 37; i++) step(1'b1, (i == 36) ? 3'd5 : 3'(i), 8'd3, 1'b1);
    chk("pre_rst_q",      32'(bus.q),           32'd5);
    chk("pre_rst_count",  32'(bus.cycle_count), 32'd37);
    chk("pre_rst_clkdiv", 32'(bus.clk_div),     32'd1);

    // Asynchronous reset mid-cycle, no clock edge in between
    rst = 1'b1;
    #1 chk_all_zero("async_rst");
    chk("async_rst_dcnt", 32'(dut.u_div.dcnt_q), 32'd0);
    model_reset();
    #1 rst = 1'b0;
    step(1'b1, 3'd2, 8'd3, 1'b1);
    chk("post_rst_count", 32'(bus.cycle_count), 32'd1);

    // Ticks on cycles 4, 8, 12 after reset
    for (int i = 2; i <= 12; i++) begin
      step(1'b1, 3'(i), 8'd3, 1'b1);
      chk("div3_tick", 32'(bus.tick), ((i % 4) == 0) ? 32'd1 : 32'd0);
    end

    // div=0: tick every cycle, clk_div at clk/2
    for (int i = 0; i < 4; i++) begin
      step(1'b1, 3'(i), 8'd0, 1'b1);
      chk("div0_tick", 32'(bus.tick), 32'd1);
    end

    // Live div change: div=10 until dcnt=7, then div=2
    guard = 0;
    while (m_dcnt != 8'd7 && guard < 20) begin
      step(1'b1, 3'd3, 8'd10, 1'b1);
      guard++;
    end
    chk("live_reach7", 32'(m_dcnt), 32'd7);
    step(1'b1, 3'd4, 8'd2, 1'b1);
    chk("live_tick", 32'(bus.tick), 32'd1);
    for (int i = 1; i <= 3; i++) begin
      step(1'b1, 3'd4, 8'd2, 1'b1);
      chk("live_period3", 32'(bus.tick), (i == 3) ? 32'd1 : 32'd0);
    end

    // Enable gating mid-period
    step(1'b1, 3'd1, 8'd2, 1'b1);
    for (int i = 0; i < 5; i++) step(1'b0, 3'(i + 2), 8'd2, 1'b1);
    for (int i = 0; i < 4; i++) step(1'b1, 3'(i), 8'd2, 1'b1);

    // Counter wrap: run quietly to near max, then check every edge
    guard = 0;
    while (m_cnt != 16'hFFFC && guard < 70000) begin
      step(1'b1, 3'd6, 8'd5, 1'b0);
      guard++;
    end
    chk("wrap_reach", 32'(m_cnt), 32'hFFFC);
    for (int i = 0; i < 5; i++) step(1'b1, 3'(i), 8'd5, 1'b1);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
